// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: turns byte/half/word requests into single-word
// read, write or read-modify-write transactions on a word-addressed data memory.
module mem_access_unit #(
    parameter int DEPTH = 32
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [8:0]  mem_ctrl,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [8:0]  CTRL_RD   = 9'h010;
    localparam logic [8:0]  CTRL_WR   = 9'h008;
    localparam logic [29:0] IDX_LIMIT = 30'(DEPTH);

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [1:0]  off_reg;
    logic [15:0] wdata_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [8:0]  mem_ctrl_reg;

    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;
    logic [3:0]  lane_sel;
    logic [31:0] merged_word;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_ctrl   = mem_ctrl_reg;

    // Indices at or beyond DEPTH are rejected rather than wrapped.
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (req_addr[31:2] >= IDX_LIMIT) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        lane_byte = mem_rdata[{off_reg, 3'b000} +: 8];
        lane_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_reg)
            2'b00:   load_data = {{24{signed_reg & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{signed_reg & lane_half[15]}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (size_reg)
            2'b00:   lane_sel = 4'b0001 << off_reg;
            2'b01:   lane_sel = off_reg[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b0000;
        endcase
    end

    // Sub-word store merge: odd lanes of a half store take the upper store byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = !lane_sel[gi] ? mem_rdata[8*gi +: 8] :
                ((size_reg == 2'b01) && (gi % 2 == 1)) ? wdata_reg[15:8] : wdata_reg[7:0];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= 2'b00;
            signed_reg     <= 1'b0;
            off_reg        <= 2'b00;
            wdata_reg      <= 16'h0000;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'h0;
            mem_addr_reg   <= 32'h0;
            mem_wdata_reg  <= 32'h0;
            mem_ctrl_reg   <= 9'h000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg       <= req_we;
                        size_reg     <= req_size;
                        signed_reg   <= req_signed;
                        off_reg      <= req_addr[1:0];
                        wdata_reg    <= req_wdata[15:0];
                        mem_addr_reg <= {2'b00, req_addr[31:2]};
                        if (req_err) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'h0;
                        end else if (!req_we || (req_size != 2'b10)) begin
                            state_reg    <= RD;
                            mem_ctrl_reg <= CTRL_RD;
                        end else begin
                            state_reg     <= WR;
                            mem_ctrl_reg  <= CTRL_WR;
                            mem_wdata_reg <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (we_reg) begin
                        state_reg     <= WR;
                        mem_ctrl_reg  <= CTRL_WR;
                        mem_wdata_reg <= merged_word;
                    end else begin
                        state_reg      <= RESP;
                        mem_ctrl_reg   <= 9'h000;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= load_data;
                    end
                end
                WR: begin
                    state_reg      <= RESP;
                    mem_ctrl_reg   <= 9'h000;
                    resp_valid_reg <= 1'b1;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'h0;
                end
                RESP: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'h0;
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_ctrl_reg <= 9'h000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized back-to-back traffic,
// checked every cycle against a transaction-level model of memory and responses.
module tb_mem_access_unit;

    localparam int DEPTH = 32;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [8:0]  mem_ctrl;

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        preload = 1'b0;
    resp_t       expq [$];
    logic [8:0]  exp_ctrl [int];
    logic [31:0] exp_addr [int];
    logic [31:0] exp_wd [int];
    int          cyc = 0;
    int          busy_until = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_acc = 0;
    int          last_resp_cyc = -100;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Data memory: read port registered on the falling edge, write on the rising edge.
    always @(negedge CLK) begin
        if (mem_ctrl[4] && mem_addr < DEPTH) mem_rdata <= mem[int'(mem_addr)];
        else mem_rdata <= $urandom;
    end
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (mem_ctrl[3] && mem_addr < DEPTH) begin
            mem[int'(mem_addr)] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(logic [31:0] w, int off, int nb, bit sg);
        longint unsigned mask, v;
        mask = (64'd1 << (8 * nb)) - 1;
        v = (64'(w) >> (8 * off)) & mask;
        if (sg && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(logic [31:0] w, int off, int nb, logic [31:0] d);
        longint unsigned mask, r;
        mask = (64'd1 << (8 * nb)) - 1;
        r = (64'(w) & ~(mask << (8 * off))) | ((64'(d) & mask) << (8 * off));
        return r[31:0];
    endfunction

    // Request accepted at the edge after the falling edge where cyc was n.
    task automatic model_accept(input int n);
        int idx, off, nb;
        logic [31:0] nw;
        resp_t r;
        idx = int'(req_addr >> 2);
        off = int'(req_addr & 32'd3);
        nb  = 1 << req_size;
        r.rdata = 32'h0;
        r.err = (req_size == 2'd3) || (off % nb != 0) || (idx >= DEPTH);
        r.due = n + 1;
        if (!r.err) begin
            if (!req_we) begin
                exp_ctrl[n+1] = 9'h010; exp_addr[n+1] = 32'(idx);
                r.rdata = m_load(ref_mem[idx], off, nb, req_signed);
                r.due = n + 2;
            end else begin
                nw = m_store(ref_mem[idx], off, nb, req_wdata);
                ref_mem[idx] = nw;
                if (nb == 4) begin
                    exp_ctrl[n+1] = 9'h008; exp_addr[n+1] = 32'(idx); exp_wd[n+1] = nw;
                    r.due = n + 2;
                end else begin
                    exp_ctrl[n+1] = 9'h010; exp_addr[n+1] = 32'(idx);
                    exp_ctrl[n+2] = 9'h008; exp_addr[n+2] = 32'(idx); exp_wd[n+2] = nw;
                    r.due = n + 3;
                end
            end
        end
        busy_until = r.due;
        last_acc = n;
        expq.push_back(r);
    endtask

    always @(negedge CLK) begin : cmp
        logic [8:0] ec;
        if (RST_N) begin
            ec = exp_ctrl.exists(cyc) ? exp_ctrl[cyc] : 9'h000;
            chk("mem_ctrl", 32'(mem_ctrl), 32'(ec));
            if (ec != 9'h000) chk("mem_addr", mem_addr, exp_addr[cyc]);
            if (ec == 9'h008) chk("mem_wdata", mem_wdata, exp_wd[cyc]);
            chk("req_ready", 32'(req_ready), 32'(cyc > busy_until));
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_rdata", resp_rdata, expq[0].rdata);
                chk("resp_err", 32'(resp_err), 32'(expq[0].err));
                last_rdata = resp_rdata;
                last_err = resp_err;
                last_resp_cyc = cyc;
                void'(expq.pop_front());
            end else begin
                chk("resp_valid_idle", 32'(resp_valid), 32'd0);
                chk("resp_rdata_idle", resp_rdata, 32'h0);
                chk("resp_err_idle", 32'(resp_err), 32'd0);
            end
            if (exp_ctrl.exists(cyc)) exp_ctrl.delete(cyc);
            if (exp_addr.exists(cyc)) exp_addr.delete(cyc);
            if (exp_wd.exists(cyc)) exp_wd.delete(cyc);
        end
    end

    task automatic issue(input bit we, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = d;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout cyc=%0d actual=ready_low required=accept", cyc);
        end else begin
            @(posedge CLK); #1;
            model_accept(cyc - 1);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_resp(input string nm, input logic [31:0] rd, input logic er, input int lat);
        chk({nm, "_rdata"}, last_rdata, rd);
        chk({nm, "_err"}, 32'(last_err), 32'(er));
        chk({nm, "_latency"}, 32'(last_resp_cyc - last_acc), 32'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        logic [29:0] idx;
        logic [1:0]  sz;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'h8899AABB;
        preload = 1'b1;
        RST_N = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1 preload = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ctrl", 32'(mem_ctrl), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        chk("model_sbyte", m_load(32'h8899AABB, 1, 1, 1'b1), 32'hFFFFFFAA);
        chk("model_uhalf", m_load(32'h8899AABB, 2, 2, 1'b0), 32'h00008899);
        chk("model_merge", m_store(32'h8899AABB, 3, 1, 32'h00000055), 32'h5599AABB);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        issue(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0); idle(5);
        expect_resp("ld_sbyte", 32'hFFFFFFAA, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0); idle(5);
        expect_resp("ld_uhalf", 32'h00008899, 1'b0, 2);
        issue(1'b0, 2'b01, 1'b1, 32'h0E, 32'h0); idle(5);
        expect_resp("ld_shalf", 32'hFFFF8899, 1'b0, 2);
        issue(1'b0, 2'b10, 1'b1, 32'h0C, 32'h0); idle(5);
        expect_resp("ld_word", 32'h8899AABB, 1'b0, 2);
        issue(1'b1, 2'b00, 1'b0, 32'h0F, 32'hFFFFFF55); idle(5);
        expect_resp("st_byte", 32'h0, 1'b0, 3);
        chk("st_byte_mem", mem[3], 32'h5599AABB);
        issue(1'b1, 2'b10, 1'b0, 32'h0C, 32'h12345678); idle(5);
        expect_resp("st_word", 32'h0, 1'b0, 2);
        chk("st_word_mem", mem[3], 32'h12345678);

        issue(1'b0, 2'b10, 1'b0, 32'h06, 32'h0); idle(4);
        expect_resp("err_misalign_w", 32'h0, 1'b1, 1);
        issue(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF); idle(4);
        expect_resp("err_misalign_h", 32'h0, 1'b1, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0); idle(4);
        expect_resp("err_range", 32'h0, 1'b1, 1);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0); idle(4);
        expect_resp("err_size", 32'h0, 1'b1, 1);

        // Abort a read-modify-write while its read strobe is on the bus.
        saved = ref_mem[3];
        issue(1'b1, 2'b00, 1'b0, 32'h0F, 32'h000000A5);
        req_valid = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_ctrl", 32'(mem_ctrl), 32'd0);
        chk("arst_addr", mem_addr, 32'h0);
        chk("arst_wdata", mem_wdata, 32'h0);
        chk("arst_valid", 32'(resp_valid), 32'd0);
        chk("arst_rdata", resp_rdata, 32'h0);
        chk("arst_err", 32'(resp_err), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        ref_mem[3] = saved;
        expq.delete(); exp_ctrl.delete(); exp_addr.delete(); exp_wd.delete();
        busy_until = cyc;
        repeat (3) @(posedge CLK);
        chk("arst_hold_ctrl", 32'(mem_ctrl), 32'd0);
        @(negedge CLK); #2 RST_N = 1'b1;
        chk("arst_no_write", mem[3], saved);
        @(posedge CLK); #1;
        issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0); idle(5);
        expect_resp("post_rst_ld", saved, 1'b0, 2);

        // Back-to-back randomized traffic with req_valid held high.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: sz = 2'b00;
                3, 4, 5: sz = 2'b01;
                6, 7, 8: sz = 2'b10;
                default: sz = 2'b11;
            endcase
            if ($urandom_range(0, 19) == 0)
                idx = $urandom_range(0, 1) ? 30'(DEPTH + $urandom_range(0, 3)) : 30'($urandom);
            else
                idx = 30'($urandom_range(0, DEPTH - 1));
            issue(i[0], sz, 1'($urandom), {idx, 2'($urandom)}, $urandom);
        end
        idle(8);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
